log_scroll_ctrl: RTL and testbench
==================================

// Module: log_scroll_ctrl
// PURPOSE
//  Write-side controller for the log display RAM (dual-port, 1-cycle registered read, row-major {row,col} addressing).
//  Accepts pixel-write and scroll commands over a valid/ready handshake.
//  Pixel writes go to the bottom row. A scroll copies every row up by one using the RAM read port,
//  then fills the bottom row with CLEAR_COLOR. Sits between game/log logic (upstream) and the log RAM (downstream).
// PARAMETERS
//  ADDR_WIDTH   10  RAM address bits; N = 2**ADDR_WIDTH pixels
//  DATA_WIDTH   2   colour depth per pixel
//  COL_BITS     5   column bits; COLS = 2**COL_BITS, ROWS = 2**(ADDR_WIDTH-COL_BITS)
//  CLEAR_COLOR  0   DATA_WIDTH-bit fill value for the new bottom row
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high reset
//  cmd_valid    in   1           command present
//  cmd_ready    out  1           controller can accept a command this cycle
//  cmd_op       in   1           0 = PIXEL, 1 = SCROLL
//  cmd_col      in   COL_BITS    bottom-row column (PIXEL only)
//  cmd_data     in   DATA_WIDTH  pixel colour (PIXEL only)
//  busy         out  1           scroll in progress
//  scroll_done  out  1           1-cycle pulse: scroll finished
//  ram_we       out  1           RAM write enable
//  ram_addr_w   out  ADDR_WIDTH  RAM write address
//  ram_din      out  DATA_WIDTH  RAM write data
//  ram_addr_r   out  ADDR_WIDTH  RAM read address
//  ram_dout     in   DATA_WIDTH  RAM read data; valid 1 cycle after ram_addr_r
// BEHAVIOUR
//  Reset values: cmd_ready=1, busy=0, scroll_done=0, ram_we=0, ram_addr_w=0, ram_addr_r=0, state=IDLE.
//  Handshake: a command is accepted on the edge where cmd_valid & cmd_ready. cmd_ready = (state==IDLE).
//  PIXEL, accepted at edge E0: in cycle 1 drive ram_we=1, ram_addr_w={ROWS-1,cmd_col}, ram_din=cmd_data (registered).
//   State stays IDLE. Back-to-back PIXEL commands give one write per cycle.
//  SCROLL, accepted at E0: state goes to COPY and busy=1. Defaults below: N=1024, COLS=32.
//   COPY, cycles 1..N-COLS (1..992): ram_addr_r = COLS, COLS+1, ..., N-1, one address per cycle.
//   Copy writes lag the reads by 1: cycles 2..N-COLS+1 drive ram_we=1, ram_addr_w = previous ram_addr_r - COLS.
//    ram_din = ram_dout, passed through combinationally.
//   FLUSH, cycle N-COLS+1 (993): no read issued; last copy write completes.
//   CLEAR, cycles N-COLS+2..N+1 (994..1025): ram_we=1, ram_addr_w = N-COLS .. N-1, ram_din = CLEAR_COLOR.
//   Cycle N+2 (1026): state=IDLE, scroll_done=1 for that cycle, busy=0, cmd_ready=1.
//  ram_we=0 in every cycle not listed above. ram_addr_r holds its last value when not in COPY.
//  Read/write in the same cycle always target different rows, so there is no RAM hazard.
//  Any command presented while busy is held off (cmd_ready=0). It is accepted in the done cycle.
//  Address counters wrap only at N-1/COLS-1 (terminal values). No arithmetic overflow is reachable.
//  Reset mid-scroll: next cycle state=IDLE and ram_we=0. The pending pipelined write is dropped.
//   The RAM is left partially scrolled; no restore. No scroll_done pulse is emitted.
//  ROWS=1: the COPY phase is empty. The controller goes straight SCROLL -> FLUSH -> CLEAR.
// STRUCTURE
//  Package log_pkg: state enum {IDLE, COPY, FLUSH, CLEAR};
//   op constants OP_PIXEL=1'b0, OP_SCROLL=1'b1; localparams COLS, ROWS, N derived from the parameters.
//  Single module, no sub-module. Contents: one read-address counter; a 1-stage write pipeline (we, addr, src-select, data);
//   the FSM. Registered outputs, except ram_din, which muxes ram_dout vs the registered data.
// TESTING  (bench instantiates log_ram_lut-equivalent RAM model)
//  1 Reset held 2 cycles, cmd_valid=1 -> cmd_ready=1, busy=0, ram_we=0, scroll_done=0; no write until reset low.
//  2 PIXEL col 0 data 3, then col 31 data 1, back-to-back -> ram_we=1 in cycles 1,2; addr_w 992, 1023; RAM holds 3, 1.
//  3 RAM preloaded ram[a]=a[1:0] (a[1:0] = address bits 1:0), SCROLL ->
//    ram[a]=(a+32)[1:0] for a<992; ram[992..1023]=0; scroll_done only in cycle 1026; busy cycles 1..1025.
//  4 SCROLL, then PIXEL col 5 data 2 held valid -> not accepted until cycle 1026; written at addr 997 in cycle 1027.
//  5 Assert reset at cycle 500 of a scroll -> cycle 501: ram_we=0, cmd_ready=1, busy=0; no scroll_done; no writes after.
//  6 Monitor port ordering during scroll -> addr_r increments 32..1023 with no gaps;
//    every copy write has addr_w = prior addr_r-32 and din = model data at that read.

Source files
------------

// File: rtl/log_pkg.sv
// Shared definitions for the log display write-side controller.
//   state_t    : controller FSM states
//   OP_*       : command opcodes carried on cmd_op
//   LOG_*      : default geometry of the log RAM
//   COLS/ROWS/N: pixel geometry derived from the defaults
package log_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        FLUSH = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic OP_PIXEL  = 1'b0;
    localparam logic OP_SCROLL = 1'b1;

    localparam int LOG_ADDR_WIDTH = 10;
    localparam int LOG_DATA_WIDTH = 2;
    localparam int LOG_COL_BITS   = 5;

    localparam int COLS = 2 ** LOG_COL_BITS;
    localparam int ROWS = 2 ** (LOG_ADDR_WIDTH - LOG_COL_BITS);
    localparam int N    = 2 ** LOG_ADDR_WIDTH;

endpackage

// File: rtl/log_scroll_ctrl.sv
// Write-side controller for the log display RAM.
// Pixel commands write one pixel into the bottom row. A scroll command copies
// every row up by one through the RAM read port, then fills the bottom row
// with CLEAR_COLOR.
//
// State table
//   IDLE  | accepting commands; pixel writes issue from here
//   COPY  | one read per cycle from row 1 upwards; writes trail by one cycle
//   FLUSH | no read; the last copy write completes
//   CLEAR | bottom row written with CLEAR_COLOR, one pixel per cycle
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op/cmd_col/cmd_data command fields (col/data used by PIXEL)
//   busy, scroll_done       scroll in progress / 1-cycle completion pulse
//   ram_we/addr_w/din       RAM write port
//   ram_addr_r/ram_dout     RAM read port (1-cycle registered read)
module log_scroll_ctrl
    import log_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = LOG_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = LOG_DATA_WIDTH,
    parameter int                    COL_BITS    = LOG_COL_BITS,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [COL_BITS-1:0]   cmd_col,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  busy,
    output logic                  scroll_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int NPIX = 2 ** ADDR_WIDTH;
    localparam int NCOL = 2 ** COL_BITS;
    localparam int NROW = NPIX / NCOL;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] BOTTOM_BASE = ADDR_WIDTH'(NPIX - NCOL);
    // First address of row 1; also the row offset between read and write.
    localparam logic [ADDR_WIDTH-1:0] FIRST_RD    = ADDR_WIDTH'(NCOL);

    state_t                state;
    state_t                state_nx;
    logic                  accept;
    logic                  src_copy;
    logic [DATA_WIDTH-1:0] data_q;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Copy writes take the RAM read data straight through; everything else
    // writes the registered pixel/clear value.
    assign ram_din = src_copy ? ram_dout : data_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && cmd_op == OP_SCROLL) begin
                    state_nx = (NROW > 1) ? COPY : FLUSH;
                end
            end
            COPY: begin
                if (ram_addr_r == LAST_ADDR) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                state_nx = CLEAR;
            end
            CLEAR: begin
                if (ram_addr_w == LAST_ADDR) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we      <= 1'b0;
            ram_addr_w  <= '0;
            ram_addr_r  <= '0;
            busy        <= 1'b0;
            scroll_done <= 1'b0;
            src_copy    <= 1'b0;
            data_q      <= '0;
        end else begin
            ram_we      <= 1'b0;
            scroll_done <= 1'b0;
            src_copy    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_PIXEL) begin
                            ram_we     <= 1'b1;
                            ram_addr_w <= BOTTOM_BASE | ADDR_WIDTH'(cmd_col);
                            data_q     <= cmd_data;
                        end else begin
                            busy <= 1'b1;
                            if (NROW > 1) begin
                                ram_addr_r <= FIRST_RD;
                            end
                        end
                    end
                end
                COPY: begin
                    // Write lands one row above the address read this cycle.
                    ram_we     <= 1'b1;
                    ram_addr_w <= ram_addr_r - FIRST_RD;
                    src_copy   <= 1'b1;
                    if (ram_addr_r != LAST_ADDR) begin
                        ram_addr_r <= ram_addr_r + ADDR_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    ram_we     <= 1'b1;
                    ram_addr_w <= BOTTOM_BASE;
                    data_q     <= CLEAR_COLOR;
                end
                CLEAR: begin
                    if (ram_addr_w != LAST_ADDR) begin
                        ram_we     <= 1'b1;
                        ram_addr_w <= ram_addr_w + ADDR_WIDTH'(1);
                    end else begin
                        busy        <= 1'b0;
                        scroll_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_scroll_ctrl.sv
module tb_log_scroll_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [4:0] cmd_col;
    logic [1:0] cmd_data;
    logic       busy;
    logic       scroll_done;
    logic       ram_we;
    logic [9:0] ram_addr_w;
    logic [1:0] ram_din;
    logic [9:0] ram_addr_r;
    logic [1:0] ram_dout;

    int checks = 0;
    int passes = 0;

    log_scroll_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_col    (cmd_col),
        .cmd_data   (cmd_data),
        .busy       (busy),
        .scroll_done(scroll_done),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din),
        .ram_addr_r (ram_addr_r),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, 1-cycle registered read, one-cycle preload.
    logic [1:0] mem [1024];
    logic       preload = 1'b0;
    int         preload_pat = 0;

    function automatic logic [1:0] pattern(input int pat, input int a);
        logic [9:0] av;
        av = 10'(a);
        if (pat == 0) return av[1:0];
        return av[6:5] + av[1:0];
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 1024; a++) mem[a] <= pattern(preload_pat, a);
        end else if (ram_we) begin
            mem[ram_addr_w] <= ram_din;
        end
        ram_dout <= mem[ram_addr_r];
    end

    logic [1:0] exp_mem [1024];
    logic [1:0] snap    [1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic do_preload(input int pat);
        preload_pat = pat;
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
        for (int a = 0; a < 1024; a++) exp_mem[a] = pattern(pat, a);
    endtask

    task automatic check_mem(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int a = 0; a < 1024; a++) begin
            if (mem[a] !== exp_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        if (bad != 0) $display("first bad address %0d: got %0d want %0d", first, mem[first], exp_mem[first]);
        chk(name, 64'(bad), 64'd0);
    endtask

    // Packs {ready, busy, done, we, addr_w, din, addr_r}; write fields masked when we=0.
    function automatic logic [63:0] pack(input logic rdy, input logic bsy, input logic dn,
                                         input logic we, input logic [9:0] aw,
                                         input logic [1:0] dd, input logic [9:0] ar);
        return 64'({rdy, bsy, dn, we, (we ? aw : 10'd0), (we ? dd : 2'd0), ar});
    endfunction

    // Scroll from IDLE. held: a PIXEL col5/data2 is presented throughout.
    // reset_at != 0: reset is raised in that cycle of the scroll.
    task automatic run_scroll(input string tag, input bit held, input int reset_at);
        int         kmax;
        logic       e_we;
        logic [9:0] e_aw;
        logic [1:0] e_din;
        logic [9:0] e_ar;
        int         bad;
        snap = exp_mem;
        kmax = (reset_at != 0) ? reset_at : 1027;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        @(posedge clk);
        #1;
        if (held) begin
            cmd_op   = 1'b0;
            cmd_col  = 5'd5;
            cmd_data = 2'd2;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int k = 1; k <= kmax; k++) begin
            e_ar  = (k <= 992) ? 10'(31 + k) : 10'd1023;
            e_we  = (k >= 2 && k <= 1025) || (held && k == 1027);
            e_aw  = 10'd0;
            e_din = 2'd0;
            if (k >= 2 && k <= 993) begin
                e_aw  = 10'(k - 2);
                e_din = snap[k + 30];
            end else if (k >= 994 && k <= 1025) begin
                e_aw  = 10'(992 + k - 994);
                e_din = 2'd0;
            end else if (k == 1027) begin
                e_aw  = 10'd997;
                e_din = 2'd2;
            end
            chk($sformatf("%s cycle %0d", tag, k),
                pack(cmd_ready, busy, scroll_done, ram_we, ram_addr_w, ram_din, ram_addr_r),
                pack(k >= 1026, k <= 1025, k == 1026, e_we, e_aw, e_din, e_ar));
            if (reset_at != 0 && k == reset_at) reset = 1'b1;
            if (k == 1027) cmd_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        if (reset_at != 0) begin
            chk({tag, " after reset"}, 64'({ram_we, cmd_ready, busy, scroll_done}), 64'({1'b0, 1'b1, 1'b0, 1'b0}));
            reset = 1'b0;
            bad = 0;
            for (int c = 0; c < 1100; c++) begin
                if (ram_we || scroll_done || busy) bad++;
                @(posedge clk);
                #1;
            end
            chk({tag, " quiet after reset"}, 64'(bad), 64'd0);
        end else begin
            for (int a = 0; a < 1024; a++) exp_mem[a] = (a < 992) ? snap[a + 32] : 2'd0;
            if (held) exp_mem[997] = 2'd2;
            check_mem({tag, " ram contents"});
        end
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic       op;
        logic [4:0] col;
        logic [1:0] data;
        logic       ready;
        logic       bsy;
        logic       we;
        logic [9:0] aw;
        logic [1:0] din;
        logic [9:0] ar;
    } vec_t;

    vec_t vecs [6];

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_col   = 5'd0;
        cmd_data  = 2'd0;
        do_preload(0);

        //         rst   vld   op    col    data  rdy   bsy   we    aw       din   ar
        vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd0,  2'd3, 1'b1, 1'b0, 1'b0, 10'd0,    2'd0, 10'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd0,  2'd3, 1'b1, 1'b0, 1'b0, 10'd0,    2'd0, 10'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd0,  2'd3, 1'b1, 1'b0, 1'b1, 10'd992,  2'd3, 10'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd31, 2'd1, 1'b1, 1'b0, 1'b1, 10'd1023, 2'd1, 10'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd7,  2'd2, 1'b1, 1'b0, 1'b0, 10'd0,    2'd0, 10'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd0,  2'd0, 1'b1, 1'b0, 1'b0, 10'd0,    2'd0, 10'd0};

        for (int i = 0; i < 6; i++) begin
            reset     = vecs[i].rst;
            cmd_valid = vecs[i].valid;
            cmd_op    = vecs[i].op;
            cmd_col   = vecs[i].col;
            cmd_data  = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("vec %0d", i),
                pack(cmd_ready, busy, scroll_done, ram_we | reset, ram_addr_w, ram_din, ram_addr_r),
                pack(vecs[i].ready, vecs[i].bsy, 1'b0, vecs[i].we | vecs[i].rst, vecs[i].aw, vecs[i].din, vecs[i].ar));
            if (i == 1) chk("no write in reset", 64'(mem[992]), 64'(exp_mem[992]));
        end
        exp_mem[992]  = 2'd3;
        exp_mem[1023] = 2'd1;
        chk("pixel ram 992", 64'(mem[992]), 64'd3);
        chk("pixel ram 1023", 64'(mem[1023]), 64'd1);

        do_preload(0);
        run_scroll("scroll", 1'b0, 0);

        do_preload(1);
        run_scroll("scroll+pixel", 1'b1, 0);

        run_scroll("scroll reset", 1'b0, 500);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
